boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 157 +++++++++++++++
 tb/tb_boot_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: receives a boot stream one byte at a time, writes it into
// instruction memory as 32-bit words, then holds the CPU in reset for a
// few cycles before letting it run.
//
// Stream layout: N[7:0], N[15:8], then N words of four bytes each, all
// little-endian. With BOOT_LOADER_CHECKSUM_EN defined, one more byte follows
// the data: the XOR of every data byte. If it does not match, the block
// stops in FAIL with err set and the CPU stays in reset.
module boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              ovf,
    output logic              err
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, HOLD, RUN, FAIL} state_t;

    localparam int unsigned DEPTH  = 32'd1 << ADDR_W;
    localparam int          HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef BOOT_LOADER_CHECKSUM_EN
    // After the last data word the checksum byte is expected.
    localparam state_t POST_LOAD = CHK;
`else
    localparam state_t POST_LOAD = HOLD;
`endif

    state_t            state;
    logic [15:0]       len;        // word count N taken from the header
    logic [15:0]       word_idx;   // index k of the word being assembled
    logic [1:0]        byte_cnt;   // byte position inside the current word
    logic [23:0]       word_buf;   // first three bytes of the current word
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              last_word;
    logic              word_fits;

    // NOTE: byte_ready is decoded from the state register alone, so it never
    // depends combinationally on byte_valid and the handshake has no loop.
    assign byte_ready = (state == LEN0) || (state == LEN1) ||
                        (state == DATA) || (state == CHK);
    assign accept     = byte_valid && byte_ready;
    assign last_word  = (word_idx == len - 16'd1);
    assign word_fits  = 32'(word_idx) < DEPTH;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of data bytes and the sticky checksum-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
            err  <= 1'b0;
        end else begin
            if (state == DATA && accept) begin
                csum <= csum ^ byte_in;
            end
            if (state == CHK && accept && byte_in != csum) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // Protocol FSM with registered write strobe, CPU reset and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here uses <= so all of them update together
        // from the values sampled before the edge.
        if (!rst_n) begin
            state      <= LEN0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'd0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN0: begin
                    if (accept) begin
                        len[7:0] <= byte_in;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len[15:8] <= byte_in;
                        word_idx  <= 16'd0;
                        byte_cnt  <= 2'd0;
                        hold_cnt  <= '0;
                        state     <= ({byte_in, len[7:0]} != 16'd0) ? DATA : POST_LOAD;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Words beyond memory depth are consumed but not written.
                            if (word_fits) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= {byte_in, word_buf};
                            end else begin
                                ovf <= 1'b1;
                            end
                            word_idx <= word_idx + 16'd1;
                            if (last_word) begin
                                state <= POST_LOAD;
                            end
                        end else begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= byte_in;
                        end
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        state <= (byte_in == csum) ? HOLD : FAIL;
                    end
                end
`endif
                HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state     <= RUN;
                        cpu_rst_n <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // RUN and FAIL are terminal until rst_n is asserted.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed self-checking bench for boot_loader.
// A cycle table covers the basic two-word load; hand-written sequences
// cover N=0, memory overflow, reset mid-load, byte_valid gaps and (when
// BOOT_LOADER_CHECKSUM_EN is defined) the checksum failure path.
module tb_boot_loader;

    localparam int AW = 2;
    localparam int HC = 4;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        crst;
        logic        dn;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          done;
    logic          ovf;
    logic          err;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cycle_cnt = 0;
    wr_t wr_q[$];

    boot_loader #(.ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Record every write strobe mid-cycle together with the edge count.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back('{imem_addr, imem_wdata, cycle_cnt});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        rst_n      = 1'b0;
        #2;
        check({tag, " rst we"},    32'(imem_we),    32'd0);
        check({tag, " rst cpu"},   32'(cpu_rst_n),  32'd0);
        check({tag, " rst done"},  32'(done),       32'd0);
        check({tag, " rst ovf"},   32'(ovf),        32'd0);
        check({tag, " rst err"},   32'(err),        32'd0);
        check({tag, " rst ready"}, 32'(byte_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        byte_in    = b;
        byte_valid = 1'b1;
        acc        = -1;
        for (int t = 0; t < 20; t++) begin
            if (byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cycle_cnt;
                break;
            end
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_accept: byte 0x%02h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_stream(input bq_t s, input int gap, output int last_acc);
        last_acc = -1;
        foreach (s[i]) begin
            send_byte(s[i], last_acc);
            for (int g = 0; g < gap; g++) begin
                byte_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input string tag, output int rel);
        rel = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                rel = cycle_cnt;
                break;
            end
        end
        check({tag, " done"}, 32'(done),      32'd1);
        check({tag, " cpu"},  32'(cpu_rst_n), 32'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        bq_t         s;
        logic [31:0] w;
        logic [7:0]  x;
        int          base;
        int          acc;
        int          rel;
        int          bad;

        // ---------------- A: two-word load, cycle by cycle -----------------
        //          byte   v     we    addr   data           crst  dn    rdy
        vecs.push_back('{8'h02, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h13, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 32'd0, 32'h00000013, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h08, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1});
`ifdef BOOT_LOADER_CHECKSUM_EN
        vecs.push_back('{8'h08, 1'b1, 1'b1, 32'd1, 32'h08000008, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h13, 1'b1, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h08, 1'b1, 1'b1, 32'd1, 32'h08000008, 1'b0, 1'b0, 1'b0});
`endif
        vecs.push_back('{8'h00, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b0});

        #1;
        do_reset("A");
        foreach (vecs[i]) begin
            byte_in    = vecs[i].b;
            byte_valid = vecs[i].v;
            @(posedge clk);
            #1;
            check($sformatf("A%0d we", i), 32'(imem_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("A%0d addr", i), 32'(imem_addr), vecs[i].addr);
                check($sformatf("A%0d data", i), imem_wdata,     vecs[i].data);
            end
            check($sformatf("A%0d cpu", i),   32'(cpu_rst_n),  32'(vecs[i].crst));
            check($sformatf("A%0d done", i),  32'(done),       32'(vecs[i].dn));
            check($sformatf("A%0d ready", i), 32'(byte_ready), 32'(vecs[i].rdy));
        end
        byte_valid = 1'b0;
        check("A ovf", 32'(ovf), 32'd0);
        check("A err", 32'(err), 32'd0);

        // ---------------- B: empty image ------------------------------------
        do_reset("B");
        base = wr_q.size();
        s = '{8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        send_stream(s, 0, acc);
        wait_done("B", rel);
        check("B release delay", 32'(rel - acc), 32'(HC));
        check("B no writes", 32'(wr_q.size() - base), 32'd0);

        // ---------------- C: five words into a four-word memory -------------
        do_reset("C");
        base = wr_q.size();
        s = '{8'h05, 8'h00};
        x = 8'h00;
        for (int k = 0; k < 5; k++) begin
            w = 32'hA0B0C000 | 32'(k);
            for (int j = 0; j < 4; j++) begin
                s.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        send_stream(s, 0, acc);
        wait_done("C", rel);
        check("C write count", 32'(wr_q.size() - base), 32'd4);
        for (int k = 0; k < 4 && base + k < wr_q.size(); k++) begin
            check($sformatf("C w%0d addr", k), 32'(wr_q[base+k].addr), 32'(k));
            check($sformatf("C w%0d data", k), wr_q[base+k].data, 32'hA0B0C000 | 32'(k));
        end
        check("C ovf", 32'(ovf), 32'd1);

        // ---------------- D: reset pulse in the middle of word 0 ------------
        do_reset("D0");
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_stream(s, 0, acc);
        do_reset("D pulse");
        base = wr_q.size();
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_LOADER_CHECKSUM_EN
        s.push_back(8'h08);
`endif
        send_stream(s, 0, acc);
        wait_done("D", rel);
        check("D write count", 32'(wr_q.size() - base), 32'd1);
        if (wr_q.size() > base) begin
            check("D addr", 32'(wr_q[base].addr), 32'd0);
            check("D data", wr_q[base].data, 32'h12345678);
        end
        check("D ovf", 32'(ovf), 32'd0);

        // ---------------- E: two-word load with byte_valid toggling ---------
        do_reset("E");
        base = wr_q.size();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08};
`ifdef BOOT_LOADER_CHECKSUM_EN
        s.push_back(8'h13);
`endif
        send_stream(s, 1, acc);
        // One idle cycle already followed the last byte inside send_stream.
        wait_done("E", rel);
        check("E release delay", 32'(rel - acc), 32'(HC));
        check("E write count", 32'(wr_q.size() - base), 32'd2);
        if (wr_q.size() >= base + 2) begin
            check("E w0 addr", 32'(wr_q[base].addr),   32'd0);
            check("E w0 data", wr_q[base].data,        32'h00000013);
            check("E w1 addr", 32'(wr_q[base+1].addr), 32'd1);
            check("E w1 data", wr_q[base+1].data,      32'h08000008);
        end

`ifdef BOOT_LOADER_CHECKSUM_EN
        // ---------------- F: wrong checksum locks the CPU in reset ----------
        do_reset("F");
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_stream(s, 0, acc);
        check("F err", 32'(err), 32'd1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            byte_in    = 8'h08;
            byte_valid = i[0];
            @(posedge clk);
            #1;
            if (cpu_rst_n !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 || err !== 1'b1) bad++;
        end
        byte_valid = 1'b0;
        check("F locked cycles violating", 32'(bad), 32'd0);
`else
        bad = 0;
        check("no checksum err", 32'(err) + 32'(bad), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
